// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio serializer slice.
// Mode encodings for mode_i and frame-geometry helper functions.
// Pure declarations, no logic.
package audio_pkg;

  localparam logic MODE_I2S = 1'b0;
  localparam logic MODE_TDM = 1'b1;

  // Number of bit clocks in one serialized frame.
  function automatic int frame_bits(input int num_ch, input int slot_w);
    return num_ch * slot_w;
  endfunction

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/audio_tdm_tx_bit_clock_gen.sv
// Bit clock generator: divides clk into sck_o with half-period div_i+1 clks.
// rise_o/fall_o strobe in the clk cycle whose edge toggles sck_o.
// Dropping en_i synchronously parks the divider and sck_o at 0.
module bit_clock_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             sck_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             wrap;

  // Next-state of the half-period counter and the bit clock level.
  always_comb begin
    wrap  = en_i && (cnt_q == div_i);
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (wrap) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Divider and bit clock registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = wrap & ~sck_q;
  assign fall_o = wrap &  sck_q;

endmodule

// File: rtl/audio_tdm_tx.sv
// Master-mode I2S/TDM audio serializer with a one-frame holding buffer.
// Frames go live at a load event; sck/ws/sd are registered and move on SCK falls.
// frame_ready_o is low while the holding buffer is full; a load with an empty buffer sends silence and sets underflow.
module audio_tdm_tx
  import audio_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DW     = 8,
  parameter int SLOT_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 mode_i,
  input  logic [DIV_W-1:0]     div_i,
  input  logic [NUM_CH*DW-1:0] frame_data_i,
  input  logic                 frame_valid_i,
  output logic                 frame_ready_o,
  output logic                 sck_o,
  output logic                 ws_o,
  output logic                 sd_o,
  output logic                 frame_start_o,
  output logic                 underflow_o,
  input  logic                 clr_underflow_i
);

  localparam int FB  = frame_bits(NUM_CH, SLOT_W);
  localparam int FW  = NUM_CH * DW;
  localparam int BCW = cnt_w(FB);
  localparam int SCW = cnt_w(NUM_CH);
  localparam int SBW = cnt_w(SLOT_W);

  localparam logic [SCW-1:0] LAST_SLOT = SCW'(NUM_CH - 1);
  localparam logic [SBW-1:0] LAST_SBIT = SBW'(SLOT_W - 1);
  localparam logic [BCW-1:0] HALF_BITS = BCW'(FB / 2);

  // Frame stored slot by slot with bit index = transmit order (MSB first, zero pad).
  typedef logic [NUM_CH-1:0][SLOT_W-1:0] slots_t;

  function automatic slots_t to_slots(input logic [FW-1:0] f);
    slots_t r;
    r = '0;
    for (int s = 0; s < NUM_CH; s++) begin
      for (int b = 0; b < DW; b++) begin
        r[s][b] = f[s*DW + DW-1-b];
      end
    end
    return r;
  endfunction

  // Holding buffer and status
  logic [FW-1:0]    hold_q;
  logic             hold_full_q;
  logic             uf_q;
  logic             en_q;
  logic             fstart_q;

  // Active frame and its per-frame settings
  slots_t           active_q;
  logic [DIV_W-1:0] div_q;
  logic             mode_q, mode_d;

  // Position within the frame
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [SCW-1:0]   slot_q, slot_d;
  logic [SBW-1:0]   sbit_q, sbit_d;

  // Serial line registers; in I2S mode sd_q doubles as the one-bit delay stage
  logic             ws_q, ws_d;
  logic             sd_q, sd_d;

  logic             first_load, wrap_load, load_evt;
  logic             last_bit, accept;
  logic             bit_tick, sck_rise;
  logic [DIV_W-1:0] div_eff;
  slots_t           new_slots;
  logic             cur_bit, nxt_bit;

  // The very first load has no latched divider yet, so it uses div_i directly.
  assign first_load = en_i & ~en_q;
  assign div_eff    = first_load ? div_i : div_q;

  bit_clock_gen #(
    .DIV_W (DIV_W)
  ) u_bit_clock_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en_i),
    .div_i  (div_eff),
    .sck_o  (sck_o),
    .rise_o (sck_rise),
    .fall_o (bit_tick)
  );

  assign last_bit  = (slot_q == LAST_SLOT) && (sbit_q == LAST_SBIT);
  assign wrap_load = bit_tick & last_bit;
  assign load_evt  = first_load | wrap_load;
  assign accept    = frame_valid_i & ~hold_full_q;
  assign new_slots = hold_full_q ? to_slots(hold_q) : '0;

  // Next bit position, next line values and the frame settings they belong to.
  always_comb begin
    sbit_d    = sbit_q;
    slot_d    = slot_q;
    bit_cnt_d = bit_cnt_q;
    if (load_evt) begin
      sbit_d    = '0;
      slot_d    = '0;
      bit_cnt_d = '0;
    end else begin
      bit_cnt_d = bit_cnt_q + BCW'(1);
      if (sbit_q == LAST_SBIT) begin
        sbit_d = '0;
        slot_d = slot_q + SCW'(1);
      end else begin
        sbit_d = sbit_q + SBW'(1);
      end
    end

    mode_d  = load_evt ? mode_i : mode_q;
    cur_bit = active_q[slot_q][sbit_q];
    nxt_bit = load_evt ? new_slots[0][0] : active_q[slot_d][sbit_d];

    if (mode_d == MODE_TDM) begin
      ws_d = (bit_cnt_d == '0);
      sd_d = nxt_bit;
    end else begin
      ws_d = (bit_cnt_d >= HALF_BITS);
      // I2S data lags one SCK; straight after enable the delay stage is empty.
      sd_d = first_load ? 1'b0 : cur_bit;
    end
  end

  // Holding buffer: filled when empty, emptied by any load event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else if (load_evt && hold_full_q) begin
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= frame_data_i;
      hold_full_q <= 1'b1;
    end
  end

  // Sticky underflow flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uf_q <= 1'b0;
    end else if (load_evt && !hold_full_q) begin
      uf_q <= 1'b1;
    end else if (clr_underflow_i) begin
      uf_q <= 1'b0;
    end
  end

  // Enable edge detector and frame_start pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      fstart_q <= 1'b0;
    end else begin
      en_q     <= en_i;
      fstart_q <= load_evt;
    end
  end

  // Serializer: load new frame settings at load events, advance on SCK falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q  <= '0;
      div_q     <= '0;
      mode_q    <= MODE_I2S;
      bit_cnt_q <= '0;
      slot_q    <= '0;
      sbit_q    <= '0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
    end else if (!en_i) begin
      bit_cnt_q <= '0;
      slot_q    <= '0;
      sbit_q    <= '0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
    end else if (load_evt || bit_tick) begin
      if (load_evt) begin
        active_q <= new_slots;
        div_q    <= div_i;
        mode_q   <= mode_i;
      end
      bit_cnt_q <= bit_cnt_d;
      slot_q    <= slot_d;
      sbit_q    <= sbit_d;
      ws_q      <= ws_d;
      sd_q      <= sd_d;
    end
  end

  // SCK cannot rise and fall in the same cycle.
  assert property (@(posedge clk) disable iff (!rst_n) !(sck_rise && bit_tick));

  assign frame_ready_o = ~hold_full_q;
  assign ws_o          = ws_q;
  assign sd_o          = sd_q;
  assign frame_start_o = fstart_q;
  assign underflow_o   = uf_q;

endmodule

// File: tb/tb_audio_tdm_tx.sv
module tb_audio_tdm_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 ch, 8-bit slots (I2S checks)
  logic        a_en = 0, a_mode = 0, a_valid = 0, a_clr = 0;
  logic [7:0]  a_div = 0;
  logic [15:0] a_data = 0;
  logic        a_ready, a_sck, a_ws, a_sd, a_fstart, a_uf;

  // Instance B: 4 ch, 16-bit slots (TDM checks)
  logic        b_en = 0, b_mode = 0, b_valid = 0, b_clr = 0;
  logic [7:0]  b_div = 0;
  logic [31:0] b_data = 0;
  logic        b_ready, b_sck, b_ws, b_sd, b_fstart, b_uf;

  audio_tdm_tx #(.NUM_CH(2), .DW(8), .SLOT_W(8), .DIV_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en_i(a_en), .mode_i(a_mode), .div_i(a_div),
    .frame_data_i(a_data), .frame_valid_i(a_valid), .frame_ready_o(a_ready),
    .sck_o(a_sck), .ws_o(a_ws), .sd_o(a_sd), .frame_start_o(a_fstart),
    .underflow_o(a_uf), .clr_underflow_i(a_clr)
  );

  audio_tdm_tx #(.NUM_CH(4), .DW(8), .SLOT_W(16), .DIV_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .en_i(b_en), .mode_i(b_mode), .div_i(b_div),
    .frame_data_i(b_data), .frame_valid_i(b_valid), .frame_ready_o(b_ready),
    .sck_o(b_sck), .ws_o(b_ws), .sd_o(b_sd), .frame_start_o(b_fstart),
    .underflow_o(b_uf), .clr_underflow_i(b_clr)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboards: expected {ws,sd} at each SCK rise
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  logic [1:0] ea, eb;
  logic       a_sck_p = 1'b0, b_sck_p = 1'b0;
  int         a_idx = 0, b_idx = 0;

  // Monitor A: compare line state at each SCK rise while expectations are queued
  always @(negedge clk) begin
    if (a_sck && !a_sck_p && exp_a.size() != 0) begin
      ea = exp_a.pop_front();
      check($sformatf("i2s_bit%0d", a_idx), {30'd0, a_ws, a_sd}, {30'd0, ea});
      a_idx++;
    end
    a_sck_p = a_sck;
  end

  // Monitor B: same for the TDM instance
  always @(negedge clk) begin
    if (b_sck && !b_sck_p && exp_b.size() != 0) begin
      eb = exp_b.pop_front();
      check($sformatf("tdm_bit%0d", b_idx), {30'd0, b_ws, b_sd}, {30'd0, eb});
      b_idx++;
    end
    b_sck_p = b_sck;
  end

  task automatic wait_fstart_a(input string name);
    int seen = 0;
    for (int i = 0; i < 600 && seen == 0; i++) begin
      @(negedge clk);
      if (a_fstart) seen = 1;
    end
    check(name, seen, 1);
  endtask

  task automatic wait_fstart_b(input string name);
    int seen = 0;
    for (int i = 0; i < 600 && seen == 0; i++) begin
      @(negedge clk);
      if (b_fstart) seen = 1;
    end
    check(name, seen, 1);
  endtask

  task automatic drain_a(input string name);
    for (int i = 0; i < 600 && exp_a.size() != 0; i++) @(negedge clk);
    check(name, exp_a.size(), 0);
  endtask

  task automatic drain_b(input string name);
    for (int i = 0; i < 600 && exp_b.size() != 0; i++) @(negedge clk);
    check(name, exp_b.size(), 0);
  endtask

  // Period and high time of a_sck, from one rise to the next, in clk cycles
  task automatic measure_a(output int per, output int hi);
    logic p;
    int   found = 0;
    per = 0;
    hi  = 0;
    p = a_sck;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (a_sck && !p) found = 1;
      p = a_sck;
    end
    if (found == 0) begin
      per = -1;
      return;
    end
    for (int i = 0; i < 400; i++) begin
      if (a_sck) hi++;
      p = a_sck;
      @(negedge clk);
      per++;
      if (a_sck && !p) return;
    end
    per = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] sdv, wsv;
    logic [63:0] sdt;
    int per, hi;

    // ---- 1: reset state ----
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_sck", a_sck, 0);
    check("rst_ws", a_ws, 0);
    check("rst_sd", a_sd, 0);
    check("rst_fstart", a_fstart, 0);
    check("rst_uf", a_uf, 0);
    check("rst_ready", a_ready, 1);
    check("rst_ready_b", b_ready, 1);

    // ---- 3: TDM, 4 ch x 16-bit slots ----
    b_data = {8'h44, 8'h33, 8'h22, 8'h11};
    b_valid = 1'b1;
    @(negedge clk);
    b_valid = 1'b0;
    check("tdm_hold_full", b_ready, 0);
    sdt = 64'h1100_2200_3300_4400;
    for (int i = 0; i < 64; i++) exp_b.push_back({(i == 0), sdt[63-i]});
    for (int i = 0; i < 64; i++) exp_b.push_back({(i == 0), 1'b0});
    b_mode = 1'b1;
    b_div  = 8'd0;
    b_en   = 1'b1;
    @(negedge clk);
    check("tdm_fstart0", b_fstart, 1);
    check("tdm_uf0", b_uf, 0);
    wait_fstart_b("tdm_fstart1");
    check("tdm_uf1", b_uf, 1);
    drain_b("tdm_drain");
    b_en = 1'b0;

    // ---- 2: I2S, 2 ch x 8 bits, div 0 ----
    a_data = {8'h3C, 8'hA5};
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    check("i2s_hold_full", a_ready, 0);
    sdv = 16'h529E;
    wsv = 16'h00FF;
    for (int i = 0; i < 16; i++) exp_a.push_back({wsv[15-i], sdv[15-i]});
    for (int i = 0; i < 16; i++) exp_a.push_back({wsv[15-i], 1'b0});
    a_mode = 1'b0;
    a_div  = 8'd0;
    a_en   = 1'b1;
    @(negedge clk);
    check("i2s_fstart0", a_fstart, 1);
    check("i2s_ready_after_load", a_ready, 1);
    check("i2s_uf0", a_uf, 0);
    measure_a(per, hi);
    check("i2s_sck_period", per, 2);
    // ---- 4: underflow on the second frame ----
    wait_fstart_a("i2s_fstart1");
    check("i2s_uf1", a_uf, 1);
    drain_a("i2s_drain");

    a_en = 1'b0;
    @(negedge clk);
    check("dis_sck", a_sck, 0);
    check("dis_ws", a_ws, 0);
    check("dis_sd", a_sd, 0);
    check("dis_uf_kept", a_uf, 1);
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check("uf_clr", a_uf, 0);
    a_en  = 1'b1;
    a_clr = 1'b1;
    @(negedge clk);
    check("uf_set_wins", a_uf, 1);
    check("uf_set_fstart", a_fstart, 1);
    a_en = 1'b0;
    @(negedge clk);
    a_clr = 1'b0;
    check("uf_clr2", a_uf, 0);

    // ---- 5: back-to-back frames ----
    a_data  = 16'h0F0F;
    a_valid = 1'b1;
    @(negedge clk);
    check("b2b_a_held", a_ready, 0);
    a_data = 16'h5AC3;
    a_en   = 1'b1;
    @(negedge clk);
    check("b2b_a_loaded", a_fstart, 1);
    check("b2b_ready_after_a", a_ready, 1);
    @(negedge clk);
    check("b2b_b_held", a_ready, 0);
    a_data = 16'h9966;
    @(negedge clk);
    check("b2b_c_waits", a_ready, 0);
    wait_fstart_a("b2b_next_load");
    check("b2b_ready_back", a_ready, 1);
    check("b2b_no_uf", a_uf, 0);
    @(negedge clk);
    a_valid = 1'b0;
    check("b2b_c_held", a_ready, 0);
    a_en = 1'b0;
    @(negedge clk);

    // ---- 6: divider and mid-frame divider change ----
    a_div = 8'd3;
    a_en  = 1'b1;
    measure_a(per, hi);
    check("div3_period", per, 8);
    check("div3_high", hi, 4);
    a_div = 8'd1;
    measure_a(per, hi);
    check("div_hold_period", per, 8);
    wait_fstart_a("div_next_frame");
    measure_a(per, hi);
    check("div1_period", per, 4);
    check("div1_high", hi, 2);
    a_en = 1'b0;
    @(negedge clk);

    // ---- 1b: reset mid-frame ----
    a_data  = 16'h1234;
    a_valid = 1'b1;
    @(negedge clk);
    a_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_valid = 1'b0;
    check("mid_hold_full", a_ready, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_sck", a_sck, 0);
    check("mid_rst_ws", a_ws, 0);
    check("mid_rst_sd", a_sd, 0);
    check("mid_rst_fstart", a_fstart, 0);
    check("mid_rst_uf", a_uf, 0);
    check("mid_rst_ready", a_ready, 1);
    a_en  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
